// File: rtl/div_sched.sv
`default_nettype none
// =============================================================================
// div / div_sched : two-port round-robin scheduler sharing one restoring divider.
// Optional macro DIV_SCHED_REM_EN adds remainder outputs r0/r1.   Rev 1.0
// =============================================================================

module div #(
  parameter int bw = 8
) (
  input  logic [bw-1:0] a,
  input  logic [bw-1:0] b,
  output logic [bw-1:0] q
);
  logic [bw:0] rem;

  always_comb begin
    rem = '0;
    q   = '0;
    for (int i = bw - 1; i >= 0; i--) begin
      rem = {rem[bw-1:0], a[i]};
      if (rem >= {1'b0, b}) begin
        rem  = rem - {1'b0, b};
        q[i] = 1'b1;
      end
    end
  end
endmodule

module div_sched #(
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [BW-1:0] a0,
  input  logic [BW-1:0] b0,
  output logic          gnt0,
  output logic          done0,
  output logic [BW-1:0] q0,
  output logic          err0,
  input  logic          req1,
  input  logic [BW-1:0] a1,
  input  logic [BW-1:0] b1,
  output logic          gnt1,
  output logic          done1,
  output logic [BW-1:0] q1,
  output logic          err1,
`ifdef DIV_SCHED_REM_EN
  output logic [BW-1:0] r0,
  output logic [BW-1:0] r1,
`endif
  output logic          busy
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state, state_next;
  logic          ptr, owner, win, take;
  logic [BW-1:0] opa, opb, quo, res_q;
  logic          div_zero;

  div #(.bw(BW)) u_div (.a(opa), .b(opb), .q(quo));

  assign div_zero = (opb == '0);
  assign res_q    = div_zero ? '1 : quo;

`ifdef DIV_SCHED_REM_EN
  logic [2*BW-1:0] prod;
  logic [BW-1:0]   res_r;
  assign prod  = quo * opb;
  assign res_r = div_zero ? opa : opa - prod[BW-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Handshake pulses are decoded from state+owner, so they last exactly one cycle.
  always_comb begin
    state_next = state;
    take       = 1'b0;
    win        = 1'b0;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    done0      = 1'b0;
    done1      = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        take = req0 | req1;
        win  = (req0 && req1) ? ptr : req1;
        if (take) state_next = CALC;
      end
      CALC: begin
        gnt0       = ~owner;
        gnt1       = owner;
        state_next = RESP;
      end
      RESP: begin
        done0      = ~owner;
        done1      = owner;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= 1'b0;
      owner <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      q0    <= '0;
      q1    <= '0;
      err0  <= 1'b0;
      err1  <= 1'b0;
`ifdef DIV_SCHED_REM_EN
      r0    <= '0;
      r1    <= '0;
`endif
    end else begin
      if (state == IDLE && take) begin
        owner <= win;
        opa   <= win ? a1 : a0;
        opb   <= win ? b1 : b0;
      end
      if (state == CALC) begin
        ptr <= ~owner;
        if (!owner) begin
          q0   <= res_q;
          err0 <= div_zero;
`ifdef DIV_SCHED_REM_EN
          r0   <= res_r;
`endif
        end else begin
          q1   <= res_q;
          err1 <= div_zero;
`ifdef DIV_SCHED_REM_EN
          r1   <= res_r;
`endif
        end
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_div_sched.sv
`default_nettype none
// Directed self-checking bench for div_sched (BW=8).
module tb_div_sched;
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [BW-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic          gnt0, done0, err0, gnt1, done1, err1, busy;
  logic [BW-1:0] q0, q1;
`ifdef DIV_SCHED_REM_EN
  logic [BW-1:0] r0, r1;
`endif
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_sched #(.BW(BW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0), .done0(done0), .q0(q0), .err0(err0),
    .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1), .done1(done1), .q1(q1), .err1(err1),
`ifdef DIV_SCHED_REM_EN
    .r0(r0), .r1(r1),
`endif
    .busy(busy)
  );

  // Handshake exclusivity holds in every cycle.
  always @(negedge clk) begin
    checks++;
    if ((gnt0 && gnt1) || (done0 && done1) || (gnt0 && done0) || (gnt1 && done1)) begin
      failures++;
      $display("FAIL exclusive got gnt=%b%b done=%b%b", gnt1, gnt0, done1, done0);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0;
    rst = 1'b1; step(); step();
    rst = 1'b0; step();
  endtask

  task automatic wait_done(input int port, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if ((port == 0 && done0) || (port == 1 && done1)) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({gnt0, gnt1, done0, done1, err0, err1, busy} !== 7'b0 || q0 !== 8'd0 || q1 !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs got q0=%0d q1=%0d busy=%b exp all zero", q0, q1, busy);
    end
    do_reset();
  endtask

  task automatic test_single();
    req0 = 1'b1; a0 = 8'd200; b0 = 8'd7;
    step();
    checks++;
    if (gnt0 !== 1'b1 || busy !== 1'b1 || done0 !== 1'b0) begin
      failures++;
      $display("FAIL single_gnt got gnt0=%b busy=%b done0=%b exp 1 1 0", gnt0, busy, done0);
    end
    step();
    checks++;
    if (done0 !== 1'b1 || gnt0 !== 1'b0 || q0 !== 8'd28 || err0 !== 1'b0) begin
      failures++;
      $display("FAIL single_done got done0=%b gnt0=%b q0=%0d err0=%b exp 1 0 28 0", done0, gnt0, q0, err0);
    end
`ifdef DIV_SCHED_REM_EN
    checks++;
    if (r0 !== 8'd4) begin failures++; $display("FAIL single_r0 got=%0d exp=4", r0); end
`endif
    req0 = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || done0 !== 1'b0 || q0 !== 8'd28) begin
      failures++;
      $display("FAIL single_idle got busy=%b done0=%b q0=%0d exp 0 0 28", busy, done0, q0);
    end
  endtask

  task automatic test_both();
    do_reset();
    req0 = 1'b1; a0 = 8'd255; b0 = 8'd16;
    req1 = 1'b1; a1 = 8'd100; b1 = 8'd10;
    step();
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      failures++; $display("FAIL both_first got gnt0=%b gnt1=%b exp 1 0", gnt0, gnt1);
    end
    step();
    checks++;
    if (done0 !== 1'b1 || q0 !== 8'd15 || busy !== 1'b1) begin
      failures++; $display("FAIL both_q0 got done0=%b q0=%0d busy=%b exp 1 15 1", done0, q0, busy);
    end
`ifdef DIV_SCHED_REM_EN
    checks++;
    if (r0 !== 8'd15) begin failures++; $display("FAIL both_r0 got=%0d exp=15", r0); end
`endif
    req0 = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || gnt1 !== 1'b0) begin
      failures++; $display("FAIL both_gap got busy=%b gnt1=%b exp 0 0", busy, gnt1);
    end
    step();
    checks++;
    if (gnt1 !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL both_second got gnt1=%b busy=%b exp 1 1", gnt1, busy);
    end
    step();
    checks++;
    if (done1 !== 1'b1 || q1 !== 8'd10 || err1 !== 1'b0 || q0 !== 8'd15) begin
      failures++; $display("FAIL both_q1 got done1=%b q1=%0d err1=%b q0=%0d exp 1 10 0 15", done1, q1, err1, q0);
    end
    req1 = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int order[6];
    do_reset();
    a0 = 8'd20; b0 = 8'd3; a1 = 8'd50; b1 = 8'd7;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 40 && n < 6; i++) begin
      step();
      if (gnt0) begin order[n] = 0; n++; end
      if (gnt1) begin order[n] = 1; n++; end
      if (done0) begin
        checks++;
        if (q0 !== 8'd6) begin failures++; $display("FAIL b2b_q0 got=%0d exp=6", q0); end
      end
      if (done1) begin
        checks++;
        if (q1 !== 8'd7) begin failures++; $display("FAIL b2b_q1 got=%0d exp=7", q1); end
      end
      req0 = !done0;
      req1 = !done1;
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (n != 6) begin failures++; $display("FAIL b2b_count got=%0d exp=6", n); end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (order[k] != (k % 2)) begin
        failures++; $display("FAIL b2b_order idx=%0d got=%0d exp=%0d", k, order[k], k % 2);
      end
    end
    for (int i = 0; i < 6 && busy; i++) step();
  endtask

  task automatic test_div0();
    bit seen;
    req1 = 1'b1; a1 = 8'd9; b1 = 8'd0;
    wait_done(1, seen);
    checks++;
    if (!seen || q1 !== 8'd255 || err1 !== 1'b1) begin
      failures++; $display("FAIL div0 got seen=%b q1=%0d err1=%b exp 1 255 1", seen, q1, err1);
    end
`ifdef DIV_SCHED_REM_EN
    checks++;
    if (r1 !== 8'd9) begin failures++; $display("FAIL div0_r1 got=%0d exp=9", r1); end
`endif
    req1 = 1'b0; step();
    req1 = 1'b1; a1 = 8'd9; b1 = 8'd3;
    wait_done(1, seen);
    checks++;
    if (!seen || q1 !== 8'd3 || err1 !== 1'b0) begin
      failures++; $display("FAIL div0_recover got seen=%b q1=%0d err1=%b exp 1 3 0", seen, q1, err1);
    end
    req1 = 1'b0; step();
  endtask

  task automatic test_reset_mid();
    bit seen;
    bit d1 = 1'b0;
    req1 = 1'b1; a1 = 8'd100; b1 = 8'd3;
    step();
    checks++;
    if (gnt1 !== 1'b1) begin failures++; $display("FAIL mid_gnt got gnt1=%b exp 1", gnt1); end
    rst = 1'b1; req1 = 1'b0;
    #1;
    checks++;
    if (gnt1 !== 1'b0 || busy !== 1'b0 || q1 !== 8'd0 || err1 !== 1'b0) begin
      failures++; $display("FAIL mid_clear got gnt1=%b busy=%b q1=%0d err1=%b exp 0 0 0 0", gnt1, busy, q1, err1);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin step(); if (done1) d1 = 1'b1; end
    checks++;
    if (d1 !== 1'b0) begin failures++; $display("FAIL mid_nodone got done1 seen=%b exp 0", d1); end
    req0 = 1'b1; a0 = 8'd50; b0 = 8'd5;
    wait_done(0, seen);
    checks++;
    if (!seen || q0 !== 8'd10) begin
      failures++; $display("FAIL mid_after got seen=%b q0=%0d exp 1 10", seen, q0);
    end
    req0 = 1'b0; step();
  endtask

  task automatic test_boundary();
    bit seen;
    logic [BW-1:0] ta [3] = '{8'd0, 8'd255, 8'd1};
    logic [BW-1:0] tb [3] = '{8'd1, 8'd255, 8'd255};
    logic [BW-1:0] tq [3] = '{8'd0, 8'd1, 8'd0};
    logic [BW-1:0] tr [3] = '{8'd0, 8'd0, 8'd1};
    req1 = 1'b1; a1 = 8'd77; b1 = 8'd7;
    wait_done(1, seen);
    req1 = 1'b0; step();
    for (int k = 0; k < 3; k++) begin
      req0 = 1'b1; a0 = ta[k]; b0 = tb[k];
      wait_done(0, seen);
      checks++;
      if (!seen || q0 !== tq[k] || err0 !== 1'b0) begin
        failures++; $display("FAIL bound_q0 idx=%0d got q0=%0d err0=%b exp %0d 0", k, q0, err0, tq[k]);
      end
`ifdef DIV_SCHED_REM_EN
      checks++;
      if (r0 !== tr[k]) begin failures++; $display("FAIL bound_r0 idx=%0d got=%0d exp=%0d", k, r0, tr[k]); end
`else
      if (tr[k] > 8'd1) $display("note: unexpected remainder table entry %0d", k);
`endif
      checks++;
      if (q1 !== 8'd11 || err1 !== 1'b0) begin
        failures++; $display("FAIL bound_hold_q1 idx=%0d got q1=%0d err1=%b exp 11 0", k, q1, err1);
      end
      req0 = 1'b0; step();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_both();
    test_back_to_back();
    test_div0();
    test_reset_mid();
    test_boundary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
